// File: rtl/bitwise_result_demux.sv
// bitwise_result_demux: routes a valid/ready byte stream into per-lane FIFOs (in_x=1 AND lane, 0 OR lane).
// Define BITWISE_RESULT_DEMUX_STATS_EN to add per-lane accept counters and a drop_stall flag.
module bitwise_result_demux #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_x,
  input  logic [W-1:0]  in_data,
  output logic          and_valid,
  input  logic          and_ready,
  output logic [W-1:0]  and_data,
  output logic          or_valid,
  input  logic          or_ready,
  output logic [W-1:0]  or_data,
  output logic [CW-1:0] and_level,
`ifdef BITWISE_RESULT_DEMUX_STATS_EN
  output logic [15:0]   and_count,
  output logic [15:0]   or_count,
  output logic          drop_stall,
`endif
  output logic [CW-1:0] or_level
);
  localparam int PW = $clog2(DEPTH);
  // Lane index 1 is the AND lane, 0 the OR lane, so in_x selects directly.
  logic [W-1:0]  mem [2][DEPTH];
  logic [PW-1:0] wr_ptr [2];
  logic [PW-1:0] rd_ptr [2];
  logic [CW-1:0] level [2];
  logic [1:0]    full, valid, rdy, push, pop;
  assign full      = {level[1] == CW'(DEPTH), level[0] == CW'(DEPTH)};
  assign valid     = {level[1] != '0, level[0] != '0};
  assign rdy       = {and_ready, or_ready};
  assign in_ready  = rst_n & ~flush & ~full[in_x];
  assign push      = {2{in_valid & in_ready}} & {in_x, ~in_x};
  assign pop       = valid & rdy;
  assign and_valid = valid[1];
  assign or_valid  = valid[0];
  assign and_data  = mem[1][rd_ptr[1]];
  assign or_data   = mem[0][rd_ptr[0]];
  assign and_level = level[1];
  assign or_level  = level[0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr[l] <= '0;
        rd_ptr[l] <= '0;
        level[l]  <= '0;
        for (int d = 0; d < DEPTH; d++) mem[l][d] <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (flush) begin
          wr_ptr[l] <= '0;
          rd_ptr[l] <= '0;
          level[l]  <= '0;
          for (int d = 0; d < DEPTH; d++) mem[l][d] <= '0;
        end else begin
          if (push[l]) begin
            mem[l][wr_ptr[l]] <= in_data;
            wr_ptr[l] <= wr_ptr[l] + PW'(1);
          end
          if (pop[l]) rd_ptr[l] <= rd_ptr[l] + PW'(1);
          level[l] <= level[l] + CW'(push[l]) - CW'(pop[l]);
        end
      end
    end
  end
`ifdef BITWISE_RESULT_DEMUX_STATS_EN
  // Counters survive flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_count <= '0;
      or_count  <= '0;
    end else begin
      if (push[1]) and_count <= and_count + 16'd1;
      if (push[0]) or_count <= or_count + 16'd1;
    end
  end
  assign drop_stall = in_valid & ~in_ready & ~flush;
`endif
endmodule

// File: doc/bitwise_result_demux.md
Name: bitwise_result_demux

Overview:
Splits one valid/ready stream of 8-bit words into two output lanes: AND lane and OR lane. Routing is selected per word by in_x: 1 goes to the AND lane, 0 goes to the OR lane. This is the distribution-side counterpart of the x-controlled AND/OR result select. Each lane has its own FIFO, so a stalled consumer on one lane never corrupts the other lane's ordering.

Parameters:
W, 8, data width of in_data and both lane outputs
DEPTH, 4, entries per lane FIFO; power of two, >= 2
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of both lane FIFOs
in_valid  input  1  input word valid
in_ready  output  1  input word accepted this cycle when in_valid & in_ready
in_x  input  1  lane select: 1 = AND lane, 0 = OR lane; stable while in_valid and not accepted
in_data  input  W  input word
and_valid  output  1  AND lane head valid
and_ready  input  1  AND lane consumer ready
and_data  output  W  AND lane head word
or_valid  output  1  OR lane head valid
or_ready  input  1  OR lane consumer ready
or_data  output  W  OR lane head word
and_level  output  CW  AND lane occupancy
or_level  output  CW  OR lane occupancy

Behaviour:
- Reset (rst_n low, async):
  - Both FIFOs empty; levels = 0; rd/wr pointers = 0.
  - and_valid = or_valid = 0; and_data = or_data = 0.
  - in_ready = 0 while rst_n low.
  - Deasserting rst_n mid-transfer loses all buffered words; no partial state survives.
- in_ready = ~flush & ~full(target lane), where target lane = in_x ? AND : OR.
  - Combinational from in_x, flush and registered level only; never from and_ready/or_ready.
- Accept: in_valid & in_ready at edge writes in_data to the target lane tail and increments its level.
- Latency: a word pushed into an empty lane is visible on <lane>_valid/<lane>_data the next cycle.
  - No same-cycle bypass.
- Pop: <lane>_valid & <lane>_ready at edge advances the lane head and decrements its level.
- <lane>_valid = (level != 0).
- <lane>_data = word at read pointer. When empty, holds its last value, or 0 after reset/flush; it is don't-care for checks.
- Simultaneous push and pop on the same lane: level unchanged, both pointers advance.
  - Allowed at any non-full level.
- Full lane (level == DEPTH): in_ready = 0 for words targeting that lane, even if that lane pops the same cycle.
  - Acceptance resumes the cycle after level drops.
  - Words for the other lane are still accepted (head-of-line block only if the current word targets the full lane).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Level is tracked separately (0..DEPTH) to distinguish full from empty.
- flush = 1 at edge: both levels and pointers go to 0 and both valids drop next cycle.
  - Any push or pop in the same cycle is discarded.
  - in_ready = 0 during flush.
- Per-lane ordering is preserved. No ordering guarantee between lanes.
- in_x or in_data changing while in_valid = 1 and not yet accepted is a protocol violation; behaviour is undefined.

Optional Feature:
Macro: BITWISE_RESULT_DEMUX_STATS_EN
- Defined:
  - Adds outputs and_count [15:0] and or_count [15:0]: total words accepted into each lane since reset.
  - Each counter increments on an accepted push to its lane and wraps 16'hFFFF -> 0.
  - Cleared by rst_n; NOT cleared by flush.
  - Adds output drop_stall: 1 in any cycle where in_valid = 1, in_ready = 0 and flush = 0.
- Undefined: these ports and all their logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset: rst_n low with in_valid = 1 -> in_ready = 0, both valids = 0, levels = 0. Release, push 8'hA5 with in_x = 1 -> next cycle and_valid = 1, and_data = A5, and_level = 1, or_valid = 0.
- Routing: push 8'h11 (x = 1), 8'h22 (x = 0), 8'h33 (x = 1) with both readies high -> AND lane emits 11 then 33; OR lane emits 22. Each appears one cycle after its push.
- Full lane: and_ready = 0, push 4 words x = 1 -> and_level = 4, in_ready = 0 for a 5th x = 1 word. A word with x = 0 (8'h77) is still accepted. Pulse and_ready one cycle -> the 5th word is accepted the following cycle.
- Wrap and concurrent push/pop: lane level held at 2 with push and pop every cycle for 10 cycles (data 0..9) -> output sequence is in order with no loss or duplication; level stays 2 throughout.
- Flush: AND level 3, OR level 1, assert flush with in_valid = 1 -> in_ready = 0; next cycle both levels = 0 and both valids = 0; the pending word is accepted once flush drops.
- STATS_EN build: 3 AND and 2 OR pushes, then flush -> and_count = 3, or_count = 2 (unchanged by flush). A stall on a full lane -> drop_stall = 1 for each stalled cycle.
